poly_mult_sequencer: RTL and testbench
======================================

// Module: poly_mult_sequencer
// PURPOSE
//   Sequencer for the basic schoolbook polynomial multiplier.
//   On a start pulse it loads both operand circular shift registers (CSR1, CSR2).
//   For each of N output coefficients it then: clears the accumulator, runs N MAC
//   cycles rotating CSR2, writes the result and rotates CSR1 by one position.
//   Sits between the host start/done handshake and the CSR/accumulator datapath.
// PARAMETERS
//   N      8              number of coefficients per polynomial; N >= 2
//   CNT_W  $clog2(N)      width of the coefficient counters and res_addr
// PORTS
//   clk        in   1      single clock; all state changes on its rising edge
//   reset      in   1      asynchronous, active-low reset (0 = reset)
//   start      in   1      request a multiplication; sampled only in IDLE
//   abort      in   1      synchronous cancel; returns to IDLE, no done pulse
//   CSR1_load  out  1      parallel-load CSR1 with operand A
//   CSR1_en    out  1      rotate CSR1 by one coefficient
//   CSR2_load  out  1      parallel-load CSR2 with operand B
//   CSR2_en    out  1      rotate CSR2 by one coefficient
//   acc_clr    out  1      clear the accumulator
//   acc_en     out  1      accumulate the current CSR1 x CSR2 product
//   res_we     out  1      write the accumulator to result memory
//   res_addr   out  CNT_W  result coefficient index for res_we
//   busy       out  1      operation in progress (LOAD..WR)
//   done       out  1      one-cycle completion pulse
// BEHAVIOUR
//   - States: IDLE, LOAD, CLR, MAC, WR, DONE.
//   - Counters: i (outer, output index) and k (inner, MAC count), both CNT_W wide.
//   - Outputs are a Moore decode of state plus counters; there are no Mealy paths.
//   - Reset (reset=0, asynchronous): state=IDLE, i=k=0.
//     All outputs read 0, including res_addr.
//   - IDLE: all outputs 0. start=1 -> LOAD.
//   - LOAD: CSR1_load=CSR2_load=1 for 1 cycle; i<=0 -> CLR.
//   - CLR: acc_clr=1 for 1 cycle; k<=0 -> MAC.
//   - MAC: acc_en=CSR2_en=1 every cycle; k increments.
//     When k==N-1 -> WR, so MAC lasts exactly N cycles.
//     CSR2 has then made a full revolution and is back in its original order.
//   - WR: res_we=1, res_addr=i, CSR1_en=1 for 1 cycle.
//     If i==N-1 -> DONE; otherwise i<=i+1 -> CLR.
//   - DONE: done=1, busy=0 for 1 cycle -> IDLE unconditionally.
//     If start is still held high, the block re-enters LOAD one cycle after IDLE.
//   - busy=1 in LOAD, CLR, MAC and WR; busy=0 in IDLE and DONE.
//   - Latency: if start is sampled at edge 0, LOAD is cycle 1.
//     WR for index i occurs at cycle 1+(i+1)(N+2); done occurs at cycle 2+N(N+2).
//     For N=8: done at cycle 82.
//   - start while busy or in DONE: ignored, with no effect on state or counters.
//   - abort=1 in any state: next state IDLE, i=k=0, no res_we and no done pulse.
//     abort wins over start when both are high in IDLE.
//   - Reset asserted mid-operation: immediate return to the reset values; no done.
//   - Counters never wrap past N-1: i and k are cleared on entry to LOAD and CLR.
//   - res_addr is held at 0 outside WR.
// TESTING
//   1 Reset: assert reset=0 mid-MAC -> all outputs 0 immediately, asynchronously;
//     release -> IDLE.
//   2 Full run, N=8, one-cycle start pulse -> exact pulse counts:
//     CSR1_load=1, CSR2_load=1, acc_clr=8, acc_en=64, CSR2_en=64, CSR1_en=8;
//     res_we=8 with res_addr 0..7 in order; done at cycle 82; busy high cycles 1..81.
//   3 Datapath check, N=4: A=[1,2,3,4], B=[1,0,0,0] through a behavioural CSR/MAC
//     model -> the result equals the model's expected coefficients.
//   4 start pulsed at cycles 10 and 40 of a run -> no extra LOAD; single done at 82.
//   5 abort during the MAC of i=3 -> IDLE next cycle; no further res_we; no done;
//     a new start then gives a full 82-cycle run.
//   6 start held high continuously -> done at 82, IDLE at 83, LOAD at 84.
//     start and abort both high in IDLE -> remain in IDLE.

Source files
------------

// File: rtl/poly_mult_sequencer.sv
// Control sequencer for a schoolbook polynomial multiplier.
// Drives the operand CSR loads and rotations, the accumulator and the result write.
//
// state | meaning
// IDLE  | waiting for start; all outputs low
// LOAD  | parallel-load both CSRs, reset output index i
// CLR   | clear accumulator, reset MAC count k
// MAC   | accumulate CSR1 x CSR2 and rotate CSR2, N cycles
// WR    | write result i, rotate CSR1 by one coefficient
// DONE  | one-cycle completion pulse
module poly_mult_sequencer #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             CSR1_load,
    output logic             CSR1_en,
    output logic             CSR2_load,
    output logic             CSR2_en,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             res_we,
    output logic [CNT_W-1:0] res_addr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CLR  = 3'd2,
        MAC  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] i_cnt, i_nxt;
    logic [CNT_W-1:0] k_cnt, k_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            i_cnt <= '0;
            k_cnt <= '0;
        end else begin
            state <= state_nxt;
            i_cnt <= i_nxt;
            k_cnt <= k_nxt;
        end
    end

    // Outputs depend only on state and counters; abort only steers the next state.
    always_comb begin
        state_nxt = state;
        i_nxt     = i_cnt;
        k_nxt     = k_cnt;
        CSR1_load = 1'b0;
        CSR1_en   = 1'b0;
        CSR2_load = 1'b0;
        CSR2_en   = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        res_we    = 1'b0;
        res_addr  = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                CSR1_load = 1'b1;
                CSR2_load = 1'b1;
                busy      = 1'b1;
                i_nxt     = '0;
                k_nxt     = '0;
                state_nxt = CLR;
            end
            CLR: begin
                acc_clr   = 1'b1;
                busy      = 1'b1;
                k_nxt     = '0;
                state_nxt = MAC;
            end
            MAC: begin
                acc_en  = 1'b1;
                CSR2_en = 1'b1;
                busy    = 1'b1;
                if (k_cnt == LAST) begin
                    k_nxt     = '0;
                    state_nxt = WR;
                end else begin
                    k_nxt = k_cnt + 1'b1;
                end
            end
            WR: begin
                res_we   = 1'b1;
                res_addr = i_cnt;
                CSR1_en  = 1'b1;
                busy     = 1'b1;
                if (i_cnt == LAST) begin
                    i_nxt     = '0;
                    state_nxt = DONE;
                end else begin
                    i_nxt     = i_cnt + 1'b1;
                    state_nxt = CLR;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                i_nxt     = '0;
                k_nxt     = '0;
            end
        endcase

        if (abort) begin
            state_nxt = IDLE;
            i_nxt     = '0;
            k_nxt     = '0;
        end
    end

endmodule

// File: tb/tb_poly_mult_sequencer.sv
// Directed bench for poly_mult_sequencer: N=8 control sequencing plus an N=4
// instance driving a behavioural CSR/MAC datapath.
module tb_poly_mult_sequencer;

    logic clk = 1'b0;
    logic reset, start, abort, start4;

    logic       c1_load, c1_en, c2_load, c2_en, acc_clr, acc_en, res_we, busy, done;
    logic [2:0] res_addr;
    logic       d4_c1_load, d4_c1_en, d4_c2_load, d4_c2_en, d4_clr, d4_acc, d4_we, d4_busy, d4_done;
    logic [1:0] d4_addr;
    logic [11:0] out8;

    always #5 clk = ~clk;

    poly_mult_sequencer #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .CSR1_load(c1_load), .CSR1_en(c1_en), .CSR2_load(c2_load), .CSR2_en(c2_en),
        .acc_clr(acc_clr), .acc_en(acc_en), .res_we(res_we), .res_addr(res_addr),
        .busy(busy), .done(done)
    );

    poly_mult_sequencer #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .abort(1'b0),
        .CSR1_load(d4_c1_load), .CSR1_en(d4_c1_en), .CSR2_load(d4_c2_load), .CSR2_en(d4_c2_en),
        .acc_clr(d4_clr), .acc_en(d4_acc), .res_we(d4_we), .res_addr(d4_addr),
        .busy(d4_busy), .done(d4_done)
    );

    assign out8 = {c1_load, c1_en, c2_load, c2_en, acc_clr, acc_en, res_we, res_addr, busy, done};

    // Behavioural datapath for the N=4 instance: heads are element 0, rotation shifts left.
    int a4[4] = '{1, 2, 3, 4};
    int b4[4] = '{1, 0, 0, 0};
    int csr1_m[4];
    int csr2_m[4];
    int acc_m;
    int res_m[4];

    always @(posedge clk) begin
        if (d4_c1_load) csr1_m <= a4;
        else if (d4_c1_en) for (int j = 0; j < 4; j++) csr1_m[j] <= csr1_m[(j + 1) % 4];
        if (d4_c2_load) csr2_m <= b4;
        else if (d4_c2_en) for (int j = 0; j < 4; j++) csr2_m[j] <= csr2_m[(j + 1) % 4];
        if (d4_clr) acc_m <= 0;
        else if (d4_acc) acc_m <= acc_m + csr1_m[0] * csr2_m[0];
        if (d4_we) res_m[d4_addr] <= acc_m;
    end

    int checks = 0;
    int failures = 0;
    int cyc;
    int n_c1l, n_c2l, n_clr, n_acc, n_c2e, n_c1e, n_we, n_done, n_busy;
    int done_cyc, busy_first, busy_last;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clr_counts();
        cyc = 0;
        n_c1l = 0; n_c2l = 0; n_clr = 0; n_acc = 0; n_c2e = 0; n_c1e = 0;
        n_we = 0; n_done = 0; n_busy = 0;
        done_cyc = -1; busy_first = -1; busy_last = -1;
    endtask

    task automatic push_addrs();
        for (int j = 0; j < 8; j++) exp_q.push_back(j);
    endtask

    // One clock: advance, then sample on the falling edge and score res_we.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (c1_load) n_c1l++;
        if (c2_load) n_c2l++;
        if (acc_clr) n_clr++;
        if (acc_en)  n_acc++;
        if (c2_en)   n_c2e++;
        if (c1_en)   n_c1e++;
        if (busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
            n_busy++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (res_we) begin
            n_we++;
            if (exp_q.size() == 0) chk("res_we_unexpected", 32'(res_addr), 32'hFFFF_FFFF);
            else chk("res_addr_order", 32'(res_addr), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; start4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(out8), 0);
        reset = 1'b1;
        step();
        chk("idle_outputs", 32'(out8), 0);

        // Full N=8 run from a one-cycle start pulse
        clr_counts(); push_addrs();
        start = 1'b1; step(); start = 1'b0;
        chk("load_cycle1", 32'(c1_load & c2_load), 1);
        repeat (89) step();
        chk("csr1_load_cnt", n_c1l, 1);
        chk("csr2_load_cnt", n_c2l, 1);
        chk("acc_clr_cnt", n_clr, 8);
        chk("acc_en_cnt", n_acc, 64);
        chk("csr2_en_cnt", n_c2e, 64);
        chk("csr1_en_cnt", n_c1e, 8);
        chk("res_we_cnt", n_we, 8);
        chk("done_cnt", n_done, 1);
        chk("done_cycle", done_cyc, 82);
        chk("busy_first", busy_first, 1);
        chk("busy_last", busy_last, 81);
        chk("busy_cycles", n_busy, 81);
        chk("addr_queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of MAC
        clr_counts();
        start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        chk("mac_before_reset", 32'(acc_en), 1);
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs", 32'(out8), 0);
        @(negedge clk) reset = 1'b1;
        step();
        chk("idle_after_reset", 32'(out8), 0);
        exp_q.delete();

        // Extra start pulses while busy are ignored
        clr_counts(); push_addrs();
        start = 1'b1; step();
        while (cyc < 90) begin
            start = (cyc == 10 || cyc == 40);
            step();
        end
        start = 1'b0;
        chk("ignored_start_loads", n_c1l, 1);
        chk("ignored_start_done_cnt", n_done, 1);
        chk("ignored_start_done_cycle", done_cyc, 82);
        chk("ignored_start_we_cnt", n_we, 8);

        // Abort during the MAC of i=3 (MAC spans cycles 33..40)
        clr_counts(); push_addrs();
        start = 1'b1; step(); start = 1'b0;
        while (cyc < 35) step();
        chk("mac_before_abort", 32'(acc_en), 1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_idle", 32'(out8), 0);
        exp_q.delete();
        repeat (60) step();
        chk("abort_we_cnt", n_we, 3);
        chk("abort_no_done", n_done, 0);
        clr_counts(); push_addrs();
        start = 1'b1; step(); start = 1'b0;
        repeat (89) step();
        chk("post_abort_done_cycle", done_cyc, 82);
        chk("post_abort_we_cnt", n_we, 8);

        // start held high continuously, then start+abort together
        clr_counts(); push_addrs();
        start = 1'b1;
        while (cyc < 82) step();
        chk("held_done_cycle", done_cyc, 82);
        step();
        chk("held_idle_83", 32'({busy, c1_load, done}), 0);
        step();
        chk("held_load_84", 32'(c1_load), 1);
        abort = 1'b1;
        repeat (4) step();
        chk("start_abort_idle", 32'(out8), 0);
        chk("start_abort_loads", n_c1l, 2);
        start = 1'b0; abort = 1'b0;
        exp_q.delete();

        // Datapath check on the N=4 instance
        clr_counts();
        start4 = 1'b1; step(); start4 = 1'b0;
        begin
            int guard = 0;
            while (!d4_done && guard < 100) begin
                step();
                guard++;
            end
        end
        chk("dp_done_cycle", cyc, 26);
        for (int j = 0; j < 4; j++) chk($sformatf("dp_res%0d", j), res_m[j], a4[j]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
